serial_pe_seq: RTL and testbench
================================

Name: serial_pe_seq

Overview:
Sequencer that drives one serial_pe through a batch of NUM_OUT dot-product outputs without testbench hand-holding.
- Per output k: reads the line count from the instruction buffer, then streams neuron/weight element addresses one per cycle with the correct ctl/vld_i framing.
- Captures the PE result and writes it into the result buffer at address k.
- Sits between the on-chip inst/neuron/weight/result buffers and serial_pe.

Parameters:
NUM_OUT, 4, outputs per batch (inst/result depth)
ADDR_W, 9, element address width for the neuron/weight buffers
LINE_ELEMS, 32, 16-bit elements per 512-bit buffer line
OUT_STRIDE, 128, element offset between consecutive outputs' operand regions (base_k = k*OUT_STRIDE)
TIMEOUT, 15, max WAIT cycles for pe_vld_o before error

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  batch start pulse, honoured only in IDLE
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the batch completes
err  out  1  sticky timeout/overflow flag, cleared by an accepted start
inst_addr  out  2  instruction buffer read address (= k)
inst_data  in  8  line count L for output k (combinational read)
weight_addr  out  ADDR_W  weight element address
neuron_addr  out  ADDR_W  neuron element address (always equal to weight_addr)
pe_ctl  out  2  to serial_pe: 01 = first, 00 = middle, 10 = last element
pe_vld_i  out  1  to serial_pe: element valid
pe_result  in  32  from serial_pe
pe_vld_o  in  1  from serial_pe: result valid
result_we  out  1  result buffer write strobe
result_addr  out  2  result buffer write address (= k)
result_wdata  out  32  result buffer write data

Behaviour:
- Reset (async, any state): FSM → IDLE, k=0, element counter e=0, wait counter=0. All outputs 0: busy, done, err, pe_vld_i, pe_ctl, result_we, addresses, result_wdata.
- States: IDLE, FETCH, RUN, WAIT, WRITE, DONE.
- IDLE: start=1 → FETCH; k=0, err cleared. start in any other state is ignored.
- FETCH (1 cycle): inst_addr=k; latch L=inst_data.
  - L=0: skip PE activity; go to WRITE with result_wdata=0.
  - L > OUT_STRIDE/LINE_ELEMS: clamp L to OUT_STRIDE/LINE_ELEMS and set err.
  - Otherwise → RUN with e=0.
- RUN: N = L*LINE_ELEMS cycles, one element per cycle, no bubbles.
  - weight_addr = neuron_addr = k*OUT_STRIDE + e; pe_vld_i=1.
  - pe_ctl = 01 when e=0, 10 when e=N-1, 00 otherwise. N ≥ 32, so 01 and 10 never collide.
  - After e=N-1 → WAIT.
- WAIT: pe_vld_i=0, pe_ctl=00, addresses hold their last value.
  - pe_vld_o=1 → latch pe_result, go to WRITE.
  - Wait counter reaches TIMEOUT → set err, result_wdata=32'hFFFF_FFFF, go to WRITE.
  - pe_vld_o is ignored in every state except WAIT.
- WRITE (1 cycle): result_we=1, result_addr=k.
  - k = NUM_OUT-1 → DONE.
  - Otherwise k++ → FETCH.
- DONE (1 cycle): done=1, busy=0 → IDLE.
- Address arithmetic is computed at ADDR_W+1 bits; it cannot exceed 2^ADDR_W-1 given NUM_OUT*OUT_STRIDE=512.
- Latency per output: 1 (FETCH) + N (RUN) + PE latency (WAIT) + 1 (WRITE).
- Elements are contiguous and monotonic; the bank line index is addr[8:5] and the lane is addr[4:0], matching the buffer organisation.

Test Plan:
- inst={4,4,4,4}, golden neuron/weight/result files, start pulse → 4 result writes at addr 0..3 matching the result file. Each RUN is exactly 128 pe_vld_i cycles at addresses 0-127 / 128-255 / 256-383 / 384-511. done pulses once; err=0.
- inst={1,2,3,4} → ctl=10 at addresses 31, 128+63, 256+95, 384+127. ctl=01 at 0/128/256/384. pe_vld_i count = 32+64+96+128.
- inst[1]=0 → no PE beats for k=1; result_wdata=0 written at addr 1; other outputs are correct.
- Stub PE that never asserts pe_vld_o for k=2 → after 15 WAIT cycles result 32'hFFFF_FFFF is written at addr 2, err=1, batch still completes. A new start clears err.
- inst[0]=9 → clamped to 4 lines (128 beats), err=1.
- Deassert rst_n mid-RUN of k=1 → all outputs 0 immediately. After release, start reruns the batch from k=0 with correct results. A start pulse while busy has no effect.

Source files
------------

// File: rtl/serial_pe_seq.sv
// serial_pe_seq: walks one serial_pe through NUM_OUT dot products.
// For each output k it fetches the line count, streams k*OUT_STRIDE+e element
// addresses with first/last framing, waits for the PE result (bounded by
// TIMEOUT) and writes it to the result buffer at address k.
module serial_pe_seq #(
  parameter int NUM_OUT    = 4,
  parameter int ADDR_W     = 9,
  parameter int LINE_ELEMS = 32,
  parameter int OUT_STRIDE = 128,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        inst_addr,
  input  logic [7:0]        inst_data,
  output logic [ADDR_W-1:0] weight_addr,
  output logic [ADDR_W-1:0] neuron_addr,
  output logic [1:0]        pe_ctl,
  output logic              pe_vld_i,
  input  logic [31:0]       pe_result,
  input  logic              pe_vld_o,
  output logic              result_we,
  output logic [1:0]        result_addr,
  output logic [31:0]       result_wdata
);

  localparam int MAX_L = OUT_STRIDE / LINE_ELEMS;  // lines that fit one output's region
  localparam int WCW   = $clog2(TIMEOUT + 1);

  typedef logic [ADDR_W-1:0] aw_t;
  typedef logic [ADDR_W:0]   aw1_t;   // one spare bit for the address sum

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_RUN, S_WAIT, S_WRITE, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  aw_t         e_q, e_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [7:0]  len_q, len_d;
  logic        err_q, err_d;
  logic [31:0] res_q, res_d;

  aw1_t n_elems;
  logic last_e;

  // Element count for the current output and last-element detect.
  assign n_elems = aw1_t'(len_q) * aw1_t'(LINE_ELEMS);
  assign last_e  = (aw1_t'(e_q) == n_elems - aw1_t'(1));

  // Operand address: contiguous region per output, element offset within it.
  assign weight_addr  = aw_t'(aw1_t'(k_q) * aw1_t'(OUT_STRIDE) + aw1_t'(e_q));
  assign neuron_addr  = weight_addr;
  assign inst_addr    = k_q;
  assign result_addr  = k_q;
  assign result_wdata = res_q;
  assign err          = err_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      e_q     <= '0;
      wcnt_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      e_q     <= e_d;
      wcnt_q  <= wcnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

  // Next-state logic and per-state outputs.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    e_d       = e_q;
    wcnt_d    = wcnt_q;
    len_d     = len_q;
    err_d     = err_q;
    res_d     = res_q;
    busy      = 1'b0;
    done      = 1'b0;
    pe_vld_i  = 1'b0;
    pe_ctl    = 2'b00;
    result_we = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          k_d     = '0;
          e_d     = '0;
          err_d   = 1'b0;
        end
      end
      S_FETCH: begin
        busy = 1'b1;
        e_d  = '0;
        if (inst_data == 8'd0) begin
          // nothing to accumulate: write a zero result without touching the PE
          len_d   = '0;
          res_d   = '0;
          state_d = S_WRITE;
        end else if (inst_data > 8'(MAX_L)) begin
          len_d   = 8'(MAX_L);
          err_d   = 1'b1;
          state_d = S_RUN;
        end else begin
          len_d   = inst_data;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy     = 1'b1;
        pe_vld_i = 1'b1;
        if (e_q == '0)  pe_ctl = 2'b01;
        else if (last_e) pe_ctl = 2'b10;
        if (last_e) begin
          // keep e so the addresses hold their final value during WAIT
          wcnt_d  = '0;
          state_d = S_WAIT;
        end else begin
          e_d = e_q + aw_t'(1);
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (pe_vld_o) begin
          res_d   = pe_result;
          state_d = S_WRITE;
        end else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          res_d   = '1;
          state_d = S_WRITE;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      S_WRITE: begin
        busy      = 1'b1;
        result_we = 1'b1;
        e_d       = '0;
        if (k_q == 2'(NUM_OUT - 1)) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_pe_seq.sv
// Bench for serial_pe_seq: stub PE over random operand memories, queue-based
// expected beat stream and per-batch reference dot products.
module tb_serial_pe_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [1:0]  inst_addr;
  logic [7:0]  inst_data;
  logic [8:0]  weight_addr, neuron_addr;
  logic [1:0]  pe_ctl;
  logic        pe_vld_i;
  logic [31:0] pe_result = '0;
  logic        pe_vld_o = 1'b0;
  logic        result_we;
  logic [1:0]  result_addr;
  logic [31:0] result_wdata;

  serial_pe_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .inst_addr(inst_addr), .inst_data(inst_data),
    .weight_addr(weight_addr), .neuron_addr(neuron_addr),
    .pe_ctl(pe_ctl), .pe_vld_i(pe_vld_i), .pe_result(pe_result), .pe_vld_o(pe_vld_o),
    .result_we(result_we), .result_addr(result_addr), .result_wdata(result_wdata)
  );

  always #5 clk = ~clk;

  logic [15:0] nm [512];
  logic [15:0] wm [512];
  logic [7:0]  inst_mem [4];
  assign inst_data = inst_mem[inst_addr];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int drop_k  = -1;   // output whose result the stub PE never returns

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stub PE: multiply-accumulate of the addressed operands, result a few cycles after 'last'.
  logic [31:0] acc = '0;
  int          cnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= 0;
      pe_vld_o <= 1'b0;
      pe_result <= '0;
    end else begin
      pe_vld_o <= (cnt == 1);
      if (cnt > 0) cnt <= cnt - 1;
      if (pe_vld_i) begin
        acc <= (pe_ctl == 2'b01 ? 32'd0 : acc) + 32'(nm[neuron_addr]) * 32'(wm[weight_addr]);
        if (pe_ctl == 2'b10) begin
          pe_result <= (pe_ctl == 2'b01 ? 32'd0 : acc) + 32'(nm[neuron_addr]) * 32'(wm[weight_addr]);
          if (int'(weight_addr >> 7) != drop_k) cnt <= $urandom_range(1, 6);
        end
      end
    end
  end

  // Expected beat stream and observed result writes.
  logic [19:0] exp_beat_q [$];
  int          wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q  [$];
  int          prev_beat = 0;
  int          last_beat_cyc [4];
  logic [31:0] exp_res [4];
  bit          exp_err;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pe_vld_i) begin
        if (exp_beat_q.size() == 0) chk("extra_beat", weight_addr, 20'hFFFFF);
        else chk("beat", {pe_ctl, neuron_addr, weight_addr}, exp_beat_q.pop_front());
        if (pe_ctl != 2'b01) chk("beat_gap", cyc, prev_beat + 1);
        prev_beat <= cyc;
        if (pe_ctl == 2'b10) last_beat_cyc[weight_addr[8:7]] <= cyc;
      end
      if (result_we) begin
        wr_addr_q.push_back(int'(result_addr));
        wr_data_q.push_back(result_wdata);
        wr_cyc_q.push_back(cyc);
      end
    end
  end

  // Reference: per output, clamp lines, sum products over the contiguous region.
  task automatic build_exp();
    exp_beat_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    exp_err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int L = int'(inst_mem[k]);
      logic [31:0] s = 0;
      if (L > 4) begin L = 4; exp_err = 1'b1; end
      for (int e = 0; e < L * 32; e++) begin
        logic [8:0] a = 9'(k * 128 + e);
        logic [1:0] c = (e == 0) ? 2'b01 : (e == L * 32 - 1) ? 2'b10 : 2'b00;
        exp_beat_q.push_back({c, a, a});
        s += 32'(nm[a]) * 32'(wm[a]);
      end
      if (L == 0) exp_res[k] = 32'd0;
      else if (k == drop_k) begin exp_res[k] = 32'hFFFF_FFFF; exp_err = 1'b1; end
      else exp_res[k] = s;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_batch(input bit poke);
    bit got_done = 1'b0;
    int nd = 0;
    build_exp();
    pulse_start();
    chk("busy_after_start", busy, 1);
    chk("err_cleared", err, 0);
    for (int i = 0; i < 3000 && !got_done; i++) begin
      @(negedge clk);
      start = (poke && i == 40);
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", got_done, 1);
    chk("busy_at_done", busy, 0);
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("done_once", nd, 0);
    chk("idle_busy", busy, 0);
    chk("err", err, exp_err);
    chk("n_writes", wr_addr_q.size(), 4);
    for (int k = 0; k < 4 && k < wr_addr_q.size(); k++) begin
      chk("wr_addr", wr_addr_q[k], k);
      chk("wr_data", wr_data_q[k], exp_res[k]);
    end
    chk("beats_left", exp_beat_q.size(), 0);
    if (drop_k >= 0 && drop_k < 4 && inst_mem[drop_k] != 0 && wr_cyc_q.size() == 4)
      chk("timeout_lat", wr_cyc_q[drop_k] - last_beat_cyc[drop_k], 16);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 512; i++) begin
      nm[i] = 16'($urandom);
      wm[i] = 16'($urandom);
    end
  endtask

  task automatic set_inst(input int a, input int b, input int c, input int d);
    inst_mem[0] = 8'(a); inst_mem[1] = 8'(b); inst_mem[2] = 8'(c); inst_mem[3] = 8'(d);
  endtask

  initial begin
    bit found;
    fill_mem();
    set_inst(4, 4, 4, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ctl", {busy, done, err, pe_vld_i, pe_ctl, result_we, inst_addr, result_addr,
                    weight_addr, neuron_addr}, 0);
    chk("rst_wdata", result_wdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_batch(0);
    set_inst(1, 2, 3, 4);
    run_batch(0);
    set_inst($urandom_range(1, 4), 0, $urandom_range(1, 4), $urandom_range(1, 4));
    run_batch(0);
    drop_k = 2;
    set_inst(4, 4, 4, 4);
    run_batch(0);
    drop_k = -1;
    set_inst(9, 2, 4, 1);
    run_batch(0);
    for (int t = 0; t < 4; t++) begin
      fill_mem();
      set_inst($urandom_range(0, 10), $urandom_range(0, 10), $urandom_range(0, 10),
               $urandom_range(0, 10));
      drop_k = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
      run_batch(t[0]);
    end
    drop_k = -1;

    // Reset in the middle of output 1's element stream, then rerun the batch.
    set_inst(4, 4, 4, 4);
    build_exp();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (pe_vld_i && weight_addr >= 9'd128) found = 1'b1;
    end
    chk("reach_k1", found, 1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", {busy, done, err, pe_vld_i, pe_ctl, result_we, inst_addr, result_addr,
                        weight_addr, neuron_addr}, 0);
    chk("rst_mid_wdata", result_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_batch(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
